// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU op/unit encodings, tag width default and fixed unit latencies
package fpu_pkg;

    localparam int TAG_W_DEF = 5;

    // Fixed pipeline depths of the non-divider units; the divider depth is a top parameter.
    localparam logic [3:0] LAT_ABS = 4'd1;
    localparam logic [3:0] LAT_ADD = 4'd2;
    localparam logic [3:0] LAT_MUL = 4'd2;

    typedef enum logic [3:0] {
        FABS = 4'd0,
        FNEG = 4'd1,
        FADD = 4'd2,
        FSUB = 4'd3,
        FMUL = 4'd4,
        FDIV = 4'd5
    } op_e;

    typedef enum logic [1:0] {
        UNIT_ABS = 2'd0,
        UNIT_ADD = 2'd1,
        UNIT_MUL = 2'd2,
        UNIT_DIV = 2'd3
    } unit_e;

endpackage

// File: rtl/fpu_wb_resv.sv
// rtl/fpu_wb_resv.sv - 8-slot writeback reservation shift register
// Ports: clk/rstn (sync active-low), clear (drop all reservations),
//        ins_valid/ins_idx/ins_unit/ins_tag (reserve slot ins_idx after this cycle's shift),
//        query_idx -> query_occ (slot occupied now; index 8 is never occupied),
//        head_valid/head_unit/head_tag (slot[0]), any_valid (some slot occupied).
module fpu_wb_resv
    import fpu_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             ins_valid,
    input  logic [2:0]       ins_idx,
    input  unit_e            ins_unit,
    input  logic [TAG_W-1:0] ins_tag,
    input  logic [3:0]       query_idx,
    output logic             query_occ,
    output logic             head_valid,
    output unit_e            head_unit,
    output logic [TAG_W-1:0] head_tag,
    output logic             any_valid
);

    logic [7:0]       vld;
    unit_e            unit_q [8];
    logic [TAG_W-1:0] tag_q  [8];

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            vld <= '0;
            for (int i = 0; i < 8; i++) begin
                unit_q[i] <= UNIT_ABS;
                tag_q[i]  <= '0;
            end
        end else begin
            vld <= {1'b0, vld[7:1]};
            for (int i = 0; i < 7; i++) begin
                unit_q[i] <= unit_q[i+1];
                tag_q[i]  <= tag_q[i+1];
            end
            unit_q[7] <= UNIT_ABS;
            tag_q[7]  <= '0;
            // Later assignment overrides the shifted value for the reserved slot.
            if (ins_valid) begin
                vld[ins_idx]    <= 1'b1;
                unit_q[ins_idx] <= ins_unit;
                tag_q[ins_idx]  <= ins_tag;
            end
        end
    end

    // Querying slot[L] now is equivalent to checking slot[L-1] after the shift.
    assign query_occ  = !query_idx[3] && vld[query_idx[2:0]];
    assign head_valid = vld[0];
    assign head_unit  = unit_q[0];
    assign head_tag   = tag_q[0];
    assign any_valid  = |vld;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - FPU issue control with fixed-latency writeback scheduling
// Ports: clk, rstn (sync active-low), req_valid/req_ready/req_op/req_tag (issue handshake),
//        flush (discard in-flight ops), iss_* (one-cycle unit start strobes),
//        wb_valid/wb_unit/wb_tag (due result), err_illegal (pulse after illegal accept), busy.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TAG_W   = TAG_W_DEF,
    parameter int LAT_DIV = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             iss_abs,
    output logic             iss_neg,
    output logic             iss_add,
    output logic             iss_sub,
    output logic             iss_mul,
    output logic             iss_div,
    output logic             wb_valid,
    output logic [1:0]       wb_unit,
    output logic [TAG_W-1:0] wb_tag,
    output logic             err_illegal,
    output logic             busy
);

    logic [3:0] lat;
    unit_e      unit;
    logic       legal;
    logic       is_div;
    logic       slot_occ;
    logic       accept;
    logic       any_valid;
    logic [2:0] div_cnt;
    unit_e      head_unit;

    always_comb begin
        lat    = 4'd0;
        unit   = UNIT_ABS;
        legal  = 1'b1;
        is_div = 1'b0;
        case (req_op)
            FABS, FNEG: begin lat = LAT_ABS; unit = UNIT_ABS; end
            FADD, FSUB: begin lat = LAT_ADD; unit = UNIT_ADD; end
            FMUL:       begin lat = LAT_MUL; unit = UNIT_MUL; end
            FDIV:       begin lat = 4'(LAT_DIV); unit = UNIT_DIV; is_div = 1'b1; end
            default:    legal = 1'b0;
        endcase
    end

    // Illegal ops are always takeable; legal ops need their writeback slot free,
    // and a divide additionally needs the divider idle.
    assign req_ready = rstn && !flush &&
                       (!legal || (!slot_occ && (!is_div || div_cnt == 3'd0)));
    assign accept    = req_valid && req_ready;

    assign iss_abs = accept && (req_op == FABS || req_op == FNEG);
    assign iss_neg = accept && (req_op == FNEG);
    assign iss_add = accept && (req_op == FADD || req_op == FSUB);
    assign iss_sub = accept && (req_op == FSUB);
    assign iss_mul = accept && (req_op == FMUL);
    assign iss_div = accept && is_div;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_cnt     <= 3'd0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept && !legal;
            if (flush)
                div_cnt <= 3'd0;
            else if (accept && is_div)
                div_cnt <= 3'(LAT_DIV - 1);
            else if (div_cnt != 3'd0)
                div_cnt <= div_cnt - 3'd1;
        end
    end

    fpu_wb_resv #(.TAG_W(TAG_W)) u_resv (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (flush),
        .ins_valid  (accept && legal),
        .ins_idx    (3'(lat - 4'd1)),
        .ins_unit   (unit),
        .ins_tag    (req_tag),
        .query_idx  (lat),
        .query_occ  (slot_occ),
        .head_valid (wb_valid),
        .head_unit  (head_unit),
        .head_tag   (wb_tag),
        .any_valid  (any_valid)
    );

    assign wb_unit = head_unit;
    assign busy    = any_valid || (div_cnt != 3'd0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed self-checking bench for fpu_issue_ctrl
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [TW-1:0] req_tag;
    logic          flush;
    logic          iss_abs, iss_neg, iss_add, iss_sub, iss_mul, iss_div;
    logic          wb_valid;
    logic [1:0]    wb_unit;
    logic [TW-1:0] wb_tag;
    logic          err_illegal;
    logic          busy;

    int total = 0;
    int bad   = 0;

    fpu_issue_ctrl #(.TAG_W(TW), .LAT_DIV(8)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_tag(req_tag), .flush(flush),
        .iss_abs(iss_abs), .iss_neg(iss_neg), .iss_add(iss_add), .iss_sub(iss_sub),
        .iss_mul(iss_mul), .iss_div(iss_div), .wb_valid(wb_valid), .wb_unit(wb_unit),
        .wb_tag(wb_tag), .err_illegal(err_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge (start of the next cycle).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Move to mid-cycle for sampling.
    task automatic settle();
        #4;
    endtask

    task automatic offer(input logic [3:0] op, input logic [TW-1:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_tag   = tag;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        offer(FABS, 5'd1);
        next_cycle();
        next_cycle();
        settle();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        total++; if (iss_abs !== 1'b0) begin bad++; $display("FAIL reset_iss_abs got=%b exp=0", iss_abs); end
        total++; if ({wb_valid, wb_unit, wb_tag, busy, err_illegal} !== 10'd0)
            begin bad++; $display("FAIL reset_outs got=%b exp=0", {wb_valid, wb_unit, wb_tag, busy, err_illegal}); end
        next_cycle();
        rstn = 1'b1;
        req_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_fabs();
        offer(FABS, 5'd3);
        settle();
        total++; if ({req_ready, iss_abs, iss_neg, iss_add, iss_sub, iss_mul, iss_div} !== 7'b1100000)
            begin bad++; $display("FAIL fabs_issue got=%b exp=1100000", {req_ready, iss_abs, iss_neg, iss_add, iss_sub, iss_mul, iss_div}); end
        next_cycle();
        req_valid = 1'b0;
        settle();
        total++; if ({wb_valid, wb_unit, wb_tag} !== {1'b1, UNIT_ABS, 5'd3})
            begin bad++; $display("FAIL fabs_wb got=%b exp=%b", {wb_valid, wb_unit, wb_tag}, {1'b1, UNIT_ABS, 5'd3}); end
        next_cycle();
        settle();
        total++; if ({wb_valid, busy} !== 2'b00) begin bad++; $display("FAIL fabs_after got=%b exp=00", {wb_valid, busy}); end
        next_cycle();
    endtask

    task automatic test_fneg_fsub();
        offer(FNEG, 5'd8);
        settle();
        total++; if ({iss_abs, iss_neg, iss_add, iss_sub} !== 4'b1100)
            begin bad++; $display("FAIL fneg_strobes got=%b exp=1100", {iss_abs, iss_neg, iss_add, iss_sub}); end
        next_cycle();
        offer(FSUB, 5'd9);
        settle();
        total++; if ({iss_abs, iss_neg, iss_add, iss_sub} !== 4'b0011)
            begin bad++; $display("FAIL fsub_strobes got=%b exp=0011", {iss_abs, iss_neg, iss_add, iss_sub}); end
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        settle();
        total++; if ({wb_valid, wb_unit, wb_tag} !== {1'b1, UNIT_ADD, 5'd9})
            begin bad++; $display("FAIL fsub_wb got=%b exp=%b", {wb_valid, wb_unit, wb_tag}, {1'b1, UNIT_ADD, 5'd9}); end
        next_cycle();
    endtask

    task automatic test_slot_conflict();
        offer(FMUL, 5'd1);
        settle();
        total++; if (iss_mul !== 1'b1) begin bad++; $display("FAIL conf_mul_issue got=%b exp=1", iss_mul); end
        next_cycle();
        offer(FABS, 5'd2);
        settle();
        total++; if ({req_ready, iss_abs, wb_valid} !== 3'b000)
            begin bad++; $display("FAIL conf_stall got=%b exp=000", {req_ready, iss_abs, wb_valid}); end
        next_cycle();
        settle();
        total++; if ({req_ready, iss_abs} !== 2'b11) begin bad++; $display("FAIL conf_accept got=%b exp=11", {req_ready, iss_abs}); end
        total++; if ({wb_valid, wb_unit, wb_tag} !== {1'b1, UNIT_MUL, 5'd1})
            begin bad++; $display("FAIL conf_wb_mul got=%b exp=%b", {wb_valid, wb_unit, wb_tag}, {1'b1, UNIT_MUL, 5'd1}); end
        next_cycle();
        req_valid = 1'b0;
        settle();
        total++; if ({wb_valid, wb_unit, wb_tag} !== {1'b1, UNIT_ABS, 5'd2})
            begin bad++; $display("FAIL conf_wb_abs got=%b exp=%b", {wb_valid, wb_unit, wb_tag}, {1'b1, UNIT_ABS, 5'd2}); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic          exp_wb;
        logic [1:0]    exp_unit;
        logic [TW-1:0] exp_tag;
        offer(FDIV, 5'd4);
        settle();
        total++; if ({req_ready, iss_div} !== 2'b11) begin bad++; $display("FAIL div0_issue got=%b exp=11", {req_ready, iss_div}); end
        next_cycle();
        offer(FADD, 5'd6);
        settle();
        total++; if ({iss_add, iss_sub} !== 2'b10) begin bad++; $display("FAIL add1_issue got=%b exp=10", {iss_add, iss_sub}); end
        next_cycle();
        for (int c = 2; c <= 16; c++) begin
            if (c <= 8) offer(FDIV, 5'd5);
            else req_valid = 1'b0;
            settle();
            if (c <= 8) begin
                total++;
                if ({req_ready, iss_div} !== {2{c == 8}})
                    begin bad++; $display("FAIL div_ready c=%0d got=%b exp=%b", c, {req_ready, iss_div}, {2{c == 8}}); end
            end
            exp_wb   = (c == 3) || (c == 8) || (c == 16);
            exp_unit = (c == 3) ? UNIT_ADD : UNIT_DIV;
            exp_tag  = (c == 3) ? 5'd6 : (c == 8) ? 5'd4 : 5'd5;
            total++;
            if (wb_valid !== exp_wb || (exp_wb && {wb_unit, wb_tag} !== {exp_unit, exp_tag}))
                begin bad++; $display("FAIL div_wb c=%0d got=%b exp=%b", c, {wb_valid, wb_unit, wb_tag}, {exp_wb, exp_unit, exp_tag}); end
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        offer(4'd9, 5'd7);
        settle();
        total++; if ({req_ready, iss_abs, iss_neg, iss_add, iss_sub, iss_mul, iss_div} !== 7'b1000000)
            begin bad++; $display("FAIL ill_issue got=%b exp=1000000", {req_ready, iss_abs, iss_neg, iss_add, iss_sub, iss_mul, iss_div}); end
        next_cycle();
        req_valid = 1'b0;
        settle();
        total++; if ({err_illegal, wb_valid, busy} !== 3'b100)
            begin bad++; $display("FAIL ill_err got=%b exp=100", {err_illegal, wb_valid, busy}); end
        next_cycle();
        settle();
        total++; if ({err_illegal, wb_valid} !== 2'b00) begin bad++; $display("FAIL ill_after got=%b exp=00", {err_illegal, wb_valid}); end
        next_cycle();
    endtask

    task automatic test_flush();
        offer(FDIV, 5'd10);
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        next_cycle();
        offer(FDIV, 5'd11);
        flush = 1'b1;
        settle();
        total++; if ({req_ready, iss_div, busy} !== 3'b001)
            begin bad++; $display("FAIL flush_cycle got=%b exp=001", {req_ready, iss_div, busy}); end
        next_cycle();
        flush = 1'b0;
        settle();
        total++; if ({wb_valid, busy, req_ready, iss_div} !== 4'b0011)
            begin bad++; $display("FAIL flush_after got=%b exp=0011", {wb_valid, busy, req_ready, iss_div}); end
        next_cycle();
        req_valid = 1'b0;
        for (int c = 5; c <= 12; c++) begin
            settle();
            total++;
            if (wb_valid !== (c == 12) || (c == 12 && wb_tag !== 5'd11))
                begin bad++; $display("FAIL flush_wb c=%0d got=%b/%0d exp=%b/11", c, wb_valid, wb_tag, c == 12); end
            next_cycle();
        end
    endtask

    task automatic test_mid_reset();
        offer(FADD, 5'd9);
        settle();
        total++; if (iss_add !== 1'b1) begin bad++; $display("FAIL mrst_add got=%b exp=1", iss_add); end
        next_cycle();
        offer(FABS, 5'd12);
        rstn = 1'b0;
        settle();
        total++; if ({req_ready, iss_abs} !== 2'b00) begin bad++; $display("FAIL mrst_ready got=%b exp=00", {req_ready, iss_abs}); end
        next_cycle();
        rstn = 1'b1;
        req_valid = 1'b0;
        settle();
        total++; if ({wb_valid, wb_unit, wb_tag, busy, err_illegal} !== 10'd0)
            begin bad++; $display("FAIL mrst_outs got=%b exp=0", {wb_valid, wb_unit, wb_tag, busy, err_illegal}); end
        next_cycle();
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_tag   = '0;
        flush     = 1'b0;
        #1;
        test_reset();
        test_fabs();
        test_fneg_fsub();
        test_slot_conflict();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 5, width of the request/writeback tag.
REQ-002 SHALL have parameter LAT_DIV, default 8, fixed fdiv latency in cycles, range 2..8.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  an operation is offered.
REQ-006 SHALL have port req_ready  output  1  the offered operation can be accepted this cycle.
REQ-007 SHALL have port req_op  input  4  operation code (fpu_pkg op enum).
REQ-008 SHALL have port req_tag  input  TAG_W  destination tag, returned on writeback.
REQ-009 SHALL have port flush  input  1  discard all in-flight operations.
REQ-010 SHALL have ports iss_abs, iss_neg, iss_add, iss_sub, iss_mul, iss_div  output  1 each  one-cycle start strobes to the fabs/fneg, fadd, fmul and fdiv units.
REQ-011 SHALL have port wb_valid  output  1  a result is due this cycle.
REQ-012 SHALL have port wb_unit  output  2  unit whose result is muxed to the register file (fpu_pkg unit enum).
REQ-013 SHALL have port wb_tag  output  TAG_W  tag of the due result.
REQ-014 SHALL have port err_illegal  output  1  one-cycle pulse after acceptance of an undefined op.
REQ-015 SHALL have port busy  output  1  any operation in flight.

Function
REQ-016 SHALL encode ops FABS=0, FNEG=1, FADD=2, FSUB=3, FMUL=4, FDIV=5; codes 6..15 are illegal.
REQ-017 SHALL use fixed latencies: FABS/FNEG 1 (UNIT_ABS), FADD/FSUB 2 (UNIT_ADD), FMUL 2 (UNIT_MUL), FDIV LAT_DIV (UNIT_DIV).
REQ-018 SHALL accept a request in cycle t iff req_valid and req_ready are both high at the rising edge ending cycle t.
REQ-019 SHALL drive the matching iss_* strobe combinationally high in cycle t of acceptance only; FSUB asserts iss_add and iss_sub; FNEG asserts iss_abs and iss_neg.
REQ-020 SHALL hold an 8-entry writeback reservation shift register, slot[0..7], each entry {valid, unit, tag}, shifting slot[i] <= slot[i+1] every cycle, slot[7] refilled with invalid.
REQ-021 SHALL write an accepted op of latency L into slot[L-1] after the shift, so wb_valid/wb_unit/wb_tag, driven directly from slot[0], present it in cycle t+L.
REQ-022 SHALL deassert req_ready when slot[L] is valid for the offered op's L (L=8 never conflicts on slots).
REQ-023 SHALL hold a divider counter loaded with LAT_DIV-1 on FDIV acceptance, decremented to 0; req_ready for FDIV requires counter == 0 (back-to-back fdiv every LAT_DIV cycles).
REQ-024 SHALL keep req_ready high for illegal ops; accepted illegal ops reserve no slot, strobe nothing, and pulse err_illegal in cycle t+1.
REQ-025 SHALL make req_ready depend only on req_op, register state and flush, never on req_valid.
REQ-026 SHALL on flush high at an edge clear all slots and the divider counter; req_ready and all iss_* are low during a flush cycle; wb_valid is low from the next cycle.
REQ-027 SHALL drive busy = any slot valid OR divider counter != 0.

Reset
REQ-028 SHALL on rstn low at an edge clear all slots, divider counter and err_illegal; wb_valid=0, wb_unit=0, wb_tag=0, busy=0 from the next cycle.
REQ-029 SHALL hold req_ready and all iss_* low in any cycle where rstn is low; reset mid-operation discards in-flight results exactly as flush.

Structure
REQ-030 SHALL take op enum, unit enum, TAG_W default and fixed latencies from shared package fpu_pkg.
REQ-031 SHALL implement the reservation shift register as sub-module fpu_wb_resv (insert port, slot-occupied query, slot[0] output, clear).

Verification
REQ-032 SHALL test: FABS tag 3 accepted cycle 10 -> iss_abs high cycle 10, wb_valid with wb_unit=UNIT_ABS, wb_tag=3 in cycle 11 only.
REQ-033 SHALL test: FMUL tag 1 at cycle 10, FABS tag 2 offered cycle 11 -> FABS stalled (req_ready low) in cycle 11 due to slot[1] conflict, accepted cycle 12; writebacks tag 1 at cycle 12, tag 2 at cycle 13.
REQ-034 SHALL test: FDIV tag 4 at cycle 0, FDIV tag 5 offered continuously -> accepted cycle 8, writebacks cycles 8 and 16; FADD tag 6 accepted cycle 1 writes back cycle 3.
REQ-035 SHALL test: op 9 tag 7 -> accepted immediately, no iss_*, err_illegal cycle t+1, no writeback.
REQ-036 SHALL test: FDIV at cycle 0, flush at cycle 3 -> no wb_valid from cycle 4, busy low cycle 4, new FDIV accepted cycle 4.
REQ-037 SHALL test: rstn low at cycle 5 with FADD accepted cycle 4 -> no writeback in cycle 6, all outputs at reset values.
